// File: rtl/pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// pipe_skid_reg
//   Parametrised pipeline stage register with a valid/ready handshake. It moves
//   one packed payload from stage N to stage N+1.
//   SKID=1 : main + skid register (2 entries). in_ready comes from a flop, so
//            the downstream stall never reaches upstream in the same cycle.
//   SKID=0 : single main register. in_ready = !out_valid || out_ready
//            (combinational).
//   There is no combinational path from in_* to out_* in either mode. A
//   synchronous flush kills every held entry and the entry offered in the
//   same cycle.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous reset, active-low
//   flush      in   synchronous kill of all held entries and this cycle's input
//   in_valid   in   upstream offers in_data
//   in_ready   out  stage can accept (transfer on in_valid && in_ready)
//   in_data    in   upstream payload [DATA_W]
//   out_valid  out  out_data holds a live entry
//   out_ready  in   downstream accepts (transfer on out_valid && out_ready)
//   out_data   out  head payload [DATA_W]
//   occupancy  out  live entries after the last edge, 0..2 (0..1 when SKID=0)
// -----------------------------------------------------------------------------
module pipe_skid_reg #(
   parameter int                DATA_W    = 32,
   parameter bit                SKID      = 1'b1,
   parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
);

   // The state encoding equals the occupancy, so occupancy is a plain wire from the flop.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] main_q, main_d;
   logic [DATA_W-1:0] skid_q, skid_d;
   logic              in_ready_q, in_ready_d;
   logic              in_fire, out_fire;

   assign out_valid = (state_q != ST_EMPTY);
   assign out_data  = main_q;
   assign occupancy = state_q;

   // in_ready_q is 0 during reset. It rises on the first edge after release,
   // which also gates the combinational SKID=0 ready.
   assign in_ready = SKID ? in_ready_q : (in_ready_q && (!out_valid || out_ready));
   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_valid && out_ready;

   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can
      // leave it unassigned and infer a latch.
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;

      if (flush) begin
         // The payload registers keep their contents. Only the state is killed,
         // so an input accepted in this cycle is dropped.
         state_d = ST_EMPTY;
      end else begin
         unique case (state_q)
            ST_EMPTY: begin
               if (in_fire) begin
                  main_d  = in_data;
                  state_d = ST_ONE;
               end
            end
            ST_ONE: begin
               if (in_fire && out_fire) begin
                  main_d = in_data;
               end else if (in_fire && SKID) begin
                  skid_d  = in_data;
                  state_d = ST_FULL;
               end else if (out_fire) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (out_fire) begin
                  main_d  = skid_q;
                  state_d = ST_ONE;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end

      // The registered ready looks ahead to the next state, so it never
      // depends on out_ready in the same cycle.
      in_ready_d = (state_d != ST_FULL);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_EMPTY;
         // NOTE: the payload registers are reset to RESET_VAL (the NOP
         // encoding), so a stale out_data never decodes as a real instruction.
         main_q     <= RESET_VAL;
         skid_q     <= RESET_VAL;
         in_ready_q <= 1'b0;
      end else begin
         // NOTE: sequential state is updated only with non-blocking assignments,
         // so every flop samples the values from before the edge.
         state_q    <= state_d;
         main_q     <= main_d;
         skid_q     <= skid_d;
         in_ready_q <= in_ready_d;
      end
   end

endmodule
